// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcode values, instruction field positions and
// the fetch-stage state encoding.
package sisc_pkg;

   localparam logic [3:0] OP_NOOP   = 4'h0;
   localparam logic [3:0] OP_LOD    = 4'h1;
   localparam logic [3:0] OP_STR    = 4'h2;
   localparam logic [3:0] OP_SWP    = 4'h3;
   localparam logic [3:0] OP_BRA    = 4'h4;
   localparam logic [3:0] OP_BRR    = 4'h5;
   localparam logic [3:0] OP_BNE    = 4'h6;
   localparam logic [3:0] OP_BNR    = 4'h7;
   localparam logic [3:0] OP_ALU_OP = 4'h8;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam int OPC_HI = 31;
   localparam int OPC_LO = 28;
   localparam int MM_HI  = 27;
   localparam int MM_LO  = 24;
   localparam int RD_HI  = 23;
   localparam int RD_LO  = 20;
   localparam int RS_HI  = 19;
   localparam int RS_LO  = 16;
   localparam int RT_HI  = 15;
   localparam int RT_LO  = 12;
   localparam int IMM_HI = 15;
   localparam int IMM_LO = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// Next-PC selection: increment, absolute branch target, or PC-relative
// target with a sign-extended 16-bit offset; all results wrap mod 2^ADDR_W.
module sisc_pc_next #(
   parameter int ADDR_W = 16
) (
   input  logic [ADDR_W-1:0] pc_i,
   input  logic [15:0]       br_imm_i,
   input  logic              br_sel_i,
   input  logic              branch_i,
   output logic [ADDR_W-1:0] pc_next_o
);

   logic [ADDR_W-1:0] imm_sx;
   logic [ADDR_W-1:0] imm_zx;

   assign imm_sx = ADDR_W'($signed(br_imm_i));
   assign imm_zx = ADDR_W'(br_imm_i);

   always_comb begin
      pc_next_o = pc_i + ADDR_W'(1);
      if (branch_i) begin
         pc_next_o = br_sel_i ? imm_zx : (pc_i + imm_sx);
      end
   end

endmodule

// File: rtl/sisc_fetch.sv
// SISC instruction fetch: owns PC and IR, runs the req/ack instruction read
// and applies controller branch redirects. Optional macro SISC_FETCH_TIMEOUT_EN
// adds an ack timeout that retires the fetch as a NOOP and sets fetch_err.
//
//   state | meaning
//   IDLE  | no read outstanding; fetch_start launches one, branches apply now
//   WAIT  | im_req high, im_addr held; branches are parked as pending
//   HALT  | HLT fetched; everything but rst ignored
module sisc_fetch
   import sisc_pkg::*;
#(
   parameter int                ADDR_W  = 16,
   parameter int                INSTR_W = 32,
   parameter logic [ADDR_W-1:0] RST_PC  = '0,
   parameter int                TIMEOUT = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_start,
   input  logic               pc_write,
   input  logic               pc_sel,
   input  logic               br_sel,
   input  logic [15:0]        br_imm,
   output logic               im_req,
   output logic [ADDR_W-1:0]  im_addr,
   input  logic               im_ack,
   input  logic [INSTR_W-1:0] im_rdata,
   output logic [INSTR_W-1:0] ir,
   output logic [3:0]         opcode,
   output logic [3:0]         mm,
   output logic [3:0]         rd,
   output logic [3:0]         rs,
   output logic [3:0]         rt,
   output logic [15:0]        imm,
   output logic [ADDR_W-1:0]  pc,
   output logic               ir_valid,
   output logic               fetch_busy,
   output logic               halted,
   output logic               fetch_err
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] pc_q, im_addr_q, pend_tgt_q;
   logic [ADDR_W-1:0] pc_nxt, retire_pc;
   logic [INSTR_W-1:0] ir_q;
   logic              ir_valid_q, pend_q;
   logic              br_now, rdata_hlt, tmo;

   assign br_now    = pc_write & pc_sel;
   assign rdata_hlt = (im_rdata[OPC_HI:OPC_LO] == OP_HLT);

   // Relative targets use the PC as it stands when the strobe arrives.
   sisc_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
      .pc_i      (pc_q),
      .br_imm_i  (br_imm),
      .br_sel_i  (br_sel),
      .branch_i  (br_now),
      .pc_next_o (pc_nxt)
   );

   // A strobe in the retire cycle is the latest branch, so it beats the pending one.
   assign retire_pc = (br_now || !pend_q) ? pc_nxt : pend_tgt_q;

`ifdef SISC_FETCH_TIMEOUT_EN
   logic [7:0] wcnt_q;
   logic       fetch_err_q;

   assign tmo = (state_q == WAIT) && !im_ack && (wcnt_q == 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt_q      <= '0;
         fetch_err_q <= 1'b0;
      end else begin
         if ((state_q == IDLE) && fetch_start) begin
            wcnt_q <= 8'(TIMEOUT - 1);
         end else if ((state_q == WAIT) && (wcnt_q != 8'd0)) begin
            wcnt_q <= wcnt_q - 8'd1;
         end
         if (tmo) begin
            fetch_err_q <= 1'b1;
         end
      end
   end

   assign fetch_err = fetch_err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^8'(TIMEOUT);
   assign tmo            = 1'b0;
   assign fetch_err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (fetch_start) state_d = WAIT;
         WAIT: begin
            if (im_ack) begin
               state_d = rdata_hlt ? HALT : IDLE;
            end else if (tmo) begin
               state_d = IDLE;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      im_req     = (state_q == WAIT);
      fetch_busy = (state_q == WAIT);
      halted     = (state_q == HALT);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q       <= RST_PC;
         im_addr_q  <= RST_PC;
         ir_q       <= '0;
         ir_valid_q <= 1'b0;
         pend_q     <= 1'b0;
         pend_tgt_q <= RST_PC;
      end else begin
         case (state_q)
            IDLE: begin
               if (br_now) begin
                  pc_q <= pc_nxt;
               end
               if (fetch_start) begin
                  im_addr_q  <= br_now ? pc_nxt : pc_q;
                  ir_valid_q <= 1'b0;
               end
            end
            WAIT: begin
               if (im_ack) begin
                  ir_q       <= im_rdata;
                  ir_valid_q <= 1'b1;
                  pc_q       <= retire_pc;
                  pend_q     <= 1'b0;
               end else if (tmo) begin
                  ir_q       <= '0;
                  ir_valid_q <= 1'b1;
                  pc_q       <= retire_pc;
                  pend_q     <= 1'b0;
               end else if (br_now) begin
                  pend_q     <= 1'b1;
                  pend_tgt_q <= pc_nxt;
               end
            end
            default: ;
         endcase
      end
   end

   assign pc       = pc_q;
   assign im_addr  = im_addr_q;
   assign ir       = ir_q;
   assign ir_valid = ir_valid_q;
   assign opcode   = ir_q[OPC_HI:OPC_LO];
   assign mm       = ir_q[MM_HI:MM_LO];
   assign rd       = ir_q[RD_HI:RD_LO];
   assign rs       = ir_q[RS_HI:RS_LO];
   assign rt       = ir_q[RT_HI:RT_LO];
   assign imm      = ir_q[IMM_HI:IMM_LO];

endmodule

// File: tb/tb_sisc_fetch.sv
// Bench for sisc_fetch: directed scenarios with literal expectations, then
// random traffic compared every cycle against a behavioural fetch model.
module tb_sisc_fetch;

   localparam int TMO = 255;

   logic        clk = 1'b0;
   logic        rst, fetch_start, pc_write, pc_sel, br_sel, im_ack;
   logic [15:0] br_imm;
   logic [31:0] im_rdata;
   logic        im_req, ir_valid, fetch_busy, halted, fetch_err;
   logic [15:0] im_addr, pc, imm;
   logic [31:0] ir;
   logic [3:0]  opcode, mm, rd, rs, rt;

   int n_cmp = 0;
   int n_bad = 0;

   sisc_fetch #(.ADDR_W(16), .INSTR_W(32), .RST_PC(16'h0000), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc_write(pc_write),
      .pc_sel(pc_sel), .br_sel(br_sel), .br_imm(br_imm), .im_req(im_req),
      .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata), .ir(ir),
      .opcode(opcode), .mm(mm), .rd(rd), .rs(rs), .rt(rt), .imm(imm), .pc(pc),
      .ir_valid(ir_valid), .fetch_busy(fetch_busy), .halted(halted),
      .fetch_err(fetch_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a fetch is either outstanding or not; the machine is halted or not.
   bit          m_live = 0;
   bit          m_waiting, m_halted, m_valid, m_err, m_pend;
   logic [15:0] m_pc, m_addr, m_ptgt;
   logic [31:0] m_ir;
   int          m_waited;

   always @(posedge clk) begin
      logic [15:0] tgt, new_pc;
      bit          br;
      if (rst) begin
         m_live = 1; m_waiting = 0; m_halted = 0; m_valid = 0; m_err = 0; m_pend = 0;
         m_pc = 16'h0; m_addr = 16'h0; m_ir = 32'h0; m_waited = 0;
      end else if (m_live && !m_halted) begin
         br  = pc_write && pc_sel;
         tgt = br_sel ? br_imm : m_pc + br_imm;
         if (!m_waiting) begin
            if (br) m_pc = tgt;
            if (fetch_start) begin
               m_waiting = 1; m_addr = m_pc; m_valid = 0; m_waited = 0;
            end
         end else begin
            new_pc = br ? tgt : (m_pend ? m_ptgt : m_pc + 16'd1);
            if (im_ack) begin
               m_ir = im_rdata; m_valid = 1; m_pc = new_pc; m_pend = 0; m_waiting = 0;
               if (im_rdata[31:28] == 4'hF) m_halted = 1;
            end else begin
               m_waited++;
`ifdef SISC_FETCH_TIMEOUT_EN
               if (m_waited == TMO) begin
                  m_ir = 32'h0; m_valid = 1; m_err = 1; m_pc = new_pc; m_pend = 0; m_waiting = 0;
               end else
`endif
               if (br) begin
                  m_pend = 1; m_ptgt = tgt;
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         chk("m.im_req", 32'(im_req), 32'(m_waiting));
         chk("m.busy", 32'(fetch_busy), 32'(m_waiting));
         chk("m.halted", 32'(halted), 32'(m_halted));
         chk("m.pc", 32'(pc), 32'(m_pc));
         chk("m.ir", ir, m_ir);
         chk("m.ir_valid", 32'(ir_valid), 32'(m_valid));
         chk("m.fetch_err", 32'(fetch_err), 32'(m_err));
         chk("m.opcode", 32'(opcode), 32'(m_ir[31:28]));
         chk("m.mm", 32'(mm), 32'(m_ir[27:24]));
         chk("m.rd", 32'(rd), 32'(m_ir[23:20]));
         chk("m.rs", 32'(rs), 32'(m_ir[19:16]));
         chk("m.rt", 32'(rt), 32'(m_ir[15:12]));
         chk("m.imm", 32'(imm), 32'(m_ir[15:0]));
         if (m_waiting) chk("m.im_addr", 32'(im_addr), 32'(m_addr));
      end
   end

   task automatic cyc(input logic fs, input logic pw, input logic ps, input logic bs,
                      input logic [15:0] bi, input logic ack, input logic [31:0] rdat);
      fetch_start = fs; pc_write = pw; pc_sel = ps; br_sel = bs; br_imm = bi;
      im_ack = ack; im_rdata = rdat;
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 16'h0, 0, 32'h0);
   endtask

   initial begin
      int cnt;
      rst = 1'b1;
      idle(); idle();
      chk("rst.pc", 32'(pc), 32'h0);
      chk("rst.ir", ir, 32'h0);
      chk("rst.ir_valid", 32'(ir_valid), 32'h0);
      chk("rst.im_req", 32'(im_req), 32'h0);
      chk("rst.im_addr", 32'(im_addr), 32'h0);
      chk("rst.busy", 32'(fetch_busy), 32'h0);
      chk("rst.halted", 32'(halted), 32'h0);
      chk("rst.fetch_err", 32'(fetch_err), 32'h0);
      rst = 1'b0;

      // Minimum-latency fetch
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      chk("f1.im_req", 32'(im_req), 32'h1);
      chk("f1.im_addr", 32'(im_addr), 32'h0);
      chk("f1.busy", 32'(fetch_busy), 32'h1);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h81230004);
      chk("f1.ir", ir, 32'h81230004);
      chk("f1.opcode", 32'(opcode), 32'h8);
      chk("f1.mm", 32'(mm), 32'h1);
      chk("f1.rd", 32'(rd), 32'h2);
      chk("f1.rs", 32'(rs), 32'h3);
      chk("f1.imm", 32'(imm), 32'h4);
      chk("f1.pc", 32'(pc), 32'h1);
      chk("f1.ir_valid", 32'(ir_valid), 32'h1);
      chk("f1.im_req_drop", 32'(im_req), 32'h0);

      // Ack delayed five cycles
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         chk("dly.im_req", 32'(im_req), 32'h1);
         chk("dly.im_addr", 32'(im_addr), 32'h1);
         chk("dly.busy", 32'(fetch_busy), 32'h1);
         chk("dly.ir_valid", 32'(ir_valid), 32'h0);
         idle();
      end
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h12345678);
      chk("dly.ir", ir, 32'h12345678);
      chk("dly.pc", 32'(pc), 32'h2);
      idle();
      chk("dly.ir_hold", ir, 32'h12345678);
      chk("dly.pc_hold", 32'(pc), 32'h2);

      // Branches in IDLE
      cyc(0, 1, 1, 1, 16'h0010, 0, 32'h0);
      chk("br.abs", 32'(pc), 32'h10);
      cyc(0, 1, 1, 0, 16'hFFFE, 0, 32'h0);
      chk("br.rel", 32'(pc), 32'hE);
      cyc(0, 1, 0, 1, 16'h1234, 0, 32'h0);
      chk("br.pcsel0", 32'(pc), 32'hE);
      cyc(1, 1, 1, 1, 16'h0040, 0, 32'h0);
      chk("br.coinc_addr", 32'(im_addr), 32'h40);
      chk("br.coinc_req", 32'(im_req), 32'h1);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h20000000);
      chk("br.coinc_pc", 32'(pc), 32'h41);

      // Branch pending during WAIT
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      cyc(0, 1, 1, 1, 16'h0100, 0, 32'h0);
      chk("pend.pc_held", 32'(pc), 32'h41);
      chk("pend.im_addr", 32'(im_addr), 32'h41);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h30000000);
      chk("pend.pc", 32'(pc), 32'h100);

      // PC wrap
      cyc(0, 1, 1, 1, 16'hFFFF, 0, 32'h0);
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      chk("wrap.im_addr", 32'(im_addr), 32'hFFFF);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h10000000);
      chk("wrap.pc", 32'(pc), 32'h0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic fs, pw, ps, bs, ack;
         logic [3:0] op;
         rst = ((halted && $urandom_range(0, 3) == 0) || $urandom_range(0, 199) == 0);
         fs  = ($urandom_range(0, 2) == 0);
         pw  = ($urandom_range(0, 4) == 0);
         ps  = 1'($urandom);
         bs  = im_req ? 1'b1 : 1'($urandom);
         ack = im_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
         op  = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
         cyc(fs, pw, ps, bs, 16'($urandom), ack, {op, 28'($urandom)});
      end
      rst = 1'b1;
      idle();
      rst = 1'b0;

      // HLT is sticky
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'hF0000000);
      chk("hlt.halted", 32'(halted), 32'h1);
      chk("hlt.pc", 32'(pc), 32'h1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 1, 1, 16'h0055, 0, 32'h0);
         chk("hlt.no_req", 32'(im_req), 32'h0);
         chk("hlt.pc_hold", 32'(pc), 32'h1);
         chk("hlt.sticky", 32'(halted), 32'h1);
      end
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk("hlt.rst_clear", 32'(halted), 32'h0);

      // Reset mid-fetch, then a late ack
      cyc(0, 1, 1, 1, 16'h0033, 0, 32'h0);
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      chk("rstw.im_req", 32'(im_req), 32'h1);
      rst = 1'b1;
      idle();
      rst = 1'b0;
      chk("rstw.im_req_drop", 32'(im_req), 32'h0);
      chk("rstw.pc", 32'(pc), 32'h0);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h40000000);
      chk("rstw.late_ack_valid", 32'(ir_valid), 32'h0);
      chk("rstw.late_ack_ir", ir, 32'h0);

      // Ack never arrives
      cyc(1, 0, 0, 0, 16'h0, 0, 32'h0);
      cnt = 0;
      while (im_req && cnt < 300) begin
         idle();
         cnt++;
      end
`ifdef SISC_FETCH_TIMEOUT_EN
      chk("tmo.cycles", 32'(cnt), 32'(TMO));
      chk("tmo.fetch_err", 32'(fetch_err), 32'h1);
      chk("tmo.ir", ir, 32'h0);
      chk("tmo.ir_valid", 32'(ir_valid), 32'h1);
      chk("tmo.busy", 32'(fetch_busy), 32'h0);
      chk("tmo.pc", 32'(pc), 32'h1);
`else
      chk("notmo.still_req", 32'(im_req), 32'h1);
      chk("notmo.fetch_err", 32'(fetch_err), 32'h0);
      cyc(0, 0, 0, 0, 16'h0, 1, 32'h50000000);
      chk("notmo.pc", 32'(pc), 32'h1);
      chk("notmo.ir", ir, 32'h50000000);
`endif
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
